spi_slave_rx_packer: RTL
========================

// Module: spi_slave_rx_packer
// PURPOSE
//  Packs the 32-bit words produced by the SPI slave front end (already in the axi_aclk domain) into
//  AXI_DATA_WIDTH-wide beats for the AXI write path (rx_data/rx_valid/rx_ready).
//  Restarts lane packing on every new write address.
//  Discards and counts partial beats left when chip select deasserts.
//  Sits directly upstream of the AXI master plug.
// PARAMETERS
//  AXI_DATA_WIDTH  64  output beat width; must be an integer multiple of IN_WIDTH
//  IN_WIDTH        32  input word width from the SPI front end
//  (derived) RATIO = AXI_DATA_WIDTH/IN_WIDTH, LANE_W = max(1,$clog2(RATIO))
// PORTS
//  axi_aclk        in   1               clock
//  axi_aresetn     in   1               reset, synchronous, active-low
//  cs              in   1               SPI chip select, active-low (1 = no transaction)
//  addr_valid      in   1               1-cycle pulse: new transaction address latched downstream
//  in_data         in   IN_WIDTH        input word
//  in_valid        in   1               input word valid
//  in_ready        out  1               input word accepted when in_valid&&in_ready
//  rx_data         out  AXI_DATA_WIDTH  packed beat to AXI plug
//  rx_valid        out  1               packed beat valid
//  rx_ready        in   1               AXI plug accepts beat
//  word_count      out  16              beats delivered since last addr_valid
//  drop_count      out  8               partial beats discarded since reset
// BEHAVIOUR
//  - Reset (axi_aresetn==0 at posedge): in_ready=0, rx_valid=0, rx_data=0, word_count=0,
//    drop_count=0, lane=0, accumulator=0, FSM=IDLE.
//  - FSM IDLE: in_ready=0; -> FILL when cs==0 && !addr_valid.
//  - FSM FILL: -> IDLE when cs==1.
//  - Packing, little-endian: n-th accepted word of a beat goes to bits [n*IN_WIDTH +: IN_WIDTH]; lane 0 first.
//  - Lane counter increments on every accepted word. It wraps RATIO-1 -> 0.
//  - Beat completion: accepting the lane RATIO-1 word loads {in_data, accumulator} into the output register.
//    rx_valid=1 on the next cycle (latency 1 clock from last accepted word).
//  - Output register holds one beat. rx_valid stays high and rx_data stays stable until rx_ready.
//  - in_ready (comb) = FSM==FILL && cs==0 && !addr_valid && !(lane==RATIO-1 && rx_valid && !rx_ready).
//    This gives full throughput: 1 word/cycle while rx_ready is held high.
//  - RATIO==1: pure registered pass-through; lane is always 0.
//  - addr_valid pulse: in_ready=0 that cycle. Lane resets to 0 and accumulator clears.
//    word_count clears to 0 and has priority over a same-cycle increment.
//    If lane!=0, drop_count increments.
//  - cs rising with lane!=0: partial accumulator is discarded, lane=0, drop_count increments once.
//    A pending full beat in the output register is NOT dropped; it drains normally.
//  - addr_valid and cs rise in the same cycle with lane!=0: drop_count increments once only.
//  - drop_count saturates at 8'hFF. word_count wraps 16'hFFFF -> 0.
//  - word_count increments on rx_valid && rx_ready.
//  - Reset mid-transaction: all state returns to reset values at that edge; pending beat is lost.
//  - No combinational path rx_ready -> rx_valid. Only in_ready depends combinationally on
//    rx_ready, cs and addr_valid.
// STRUCTURE
//  - spi_slave_pkg: IN_WIDTH default constant (SPI_WORD_WIDTH=32) and rx_pack_state_e {IDLE,FILL}.
//  - Single module. The output register/handshake is simple enough to stay inline; no sub-module.
//  - Elaboration-time assertion: AXI_DATA_WIDTH % IN_WIDTH == 0.
// TESTING
//  - Streaming 64/32: cs=0, addr pulse, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back,
//    rx_ready=1 -> beats 0x2222222211111111 then 0x4444444433333333, each 1 clk after its 2nd word;
//    word_count=2.
//  - Backpressure: rx_ready=0 after first beat -> in_ready drops only when lane==1.
//    rx_data is stable, no word lost. Release -> sequence continues with no gap beyond stall.
//  - Partial drop: 3 words then cs=1 -> beat 1 delivered, 3rd word discarded, drop_count=1.
//    The next transaction starts at lane 0.
//  - addr_valid mid-beat: 1 word, addr pulse, 2 words 0xA, 0xB -> single beat 0x0000000B0000000A.
//    drop_count+1, word_count reset then 1.
//  - Reset: sync reset asserted with rx_valid=1 and lane=1 -> next cycle rx_valid=0, counters 0, in_ready=0.
//  - RATIO=1 (AXI_DATA_WIDTH=32): each word appears 1 clk later. drop_count never increments.
//    Random rx_ready: words arrive in order with none lost.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants and types for the SPI slave receive path.
//   SPI_WORD_WIDTH  : width of one word delivered by the SPI front end
//   rx_pack_state_e : packer FSM states (IDLE, FILL)
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int SPI_WORD_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } rx_pack_state_e;

endpackage

// File: rtl/spi_slave_rx_packer.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_packer
// Packs IN_WIDTH words from the SPI front end (already in the axi_aclk domain)
// little-endian into AXI_DATA_WIDTH beats for the AXI master plug.
// Lane packing restarts on every new write address; a partial beat left when
// chip select deasserts (or a new address arrives) is discarded and counted.
//
// Ports
//   axi_aclk, axi_aresetn : clock, synchronous active-low reset
//   cs                    : SPI chip select, active-low
//   addr_valid            : 1-cycle pulse, new transaction address
//   in_data/in_valid/in_ready : input word stream
//   rx_data/rx_valid/rx_ready : packed beat stream to the AXI plug
//   word_count            : beats delivered since last addr_valid (wraps)
//   drop_count            : partial beats discarded since reset (saturates)
// ---------------------------------------------------------------------------
module spi_slave_rx_packer
    import spi_slave_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int IN_WIDTH       = SPI_WORD_WIDTH
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cs,
    input  logic                      addr_valid,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [AXI_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [15:0]               word_count,
    output logic [7:0]                drop_count
);

    localparam int RATIO  = AXI_DATA_WIDTH / IN_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    generate
        if (AXI_DATA_WIDTH % IN_WIDTH != 0) begin : g_bad_width
            $error("AXI_DATA_WIDTH must be an integer multiple of IN_WIDTH");
        end
    endgenerate

    rx_pack_state_e            r_state;
    logic [LANE_W-1:0]         r_lane;
    logic [AXI_DATA_WIDTH-1:0] r_acc;
    logic [AXI_DATA_WIDTH-1:0] r_rx_data;
    logic                      r_rx_valid;
    logic [15:0]               r_word_count;
    logic [7:0]                r_drop_count;

    logic                      w_last_lane;
    logic                      w_stall;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_flush;
    logic                      w_drop;
    logic                      w_deliver;
    logic [AXI_DATA_WIDTH-1:0] w_beat;

    assign w_last_lane = (r_lane == LAST_LANE);
    // Only the word that completes a beat needs the output register free;
    // lower lanes go to the accumulator and can always be taken.
    assign w_stall     = w_last_lane && r_rx_valid && !rx_ready;
    assign w_in_ready  = (r_state == FILL) && !cs && !addr_valid && !w_stall;
    assign w_accept    = in_valid && w_in_ready;
    // Either a new address or a deasserted chip select abandons the partial beat.
    assign w_flush     = addr_valid || cs;
    assign w_drop      = w_flush && (r_lane != '0);
    assign w_deliver   = r_rx_valid && rx_ready;

    // Accumulator with the incoming word merged into the current lane slot.
    always_comb begin
        w_beat = r_acc;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_beat[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_acc        <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_word_count <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                IDLE:    if (!cs && !addr_valid) r_state <= FILL;
                FILL:    if (cs) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_flush) begin
                r_lane <= '0;
                r_acc  <= '0;
            end else if (w_accept) begin
                if (w_last_lane) begin
                    r_lane <= '0;
                    r_acc  <= '0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_acc  <= w_beat;
                end
            end

            // A completing word may load the register in the same cycle the
            // previous beat drains; in_ready guarantees the slot is free.
            if (w_accept && w_last_lane) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_beat;
            end else if (w_deliver) begin
                r_rx_valid <= 1'b0;
            end

            if (addr_valid) begin
                r_word_count <= '0;
            end else if (w_deliver) begin
                r_word_count <= r_word_count + 16'd1;
            end

            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign word_count = r_word_count;
    assign drop_count = r_drop_count;

endmodule
